// File: rtl/edge_density_sweep_controller.sv
// Frame sequencer for the Sobel edge-density section counters: clears counters at frame
// start, sweeps and smooths the section counts after frame end, then selects the LED section.
module edge_density_sweep_controller #(
    parameter int          WIDTH             = 640,
    parameter int          HEIGHT            = 480,
    parameter int          NUM_SECTIONS      = 18,
    parameter int          SMOOTH_FACTOR     = 2,
    parameter int          HYST_SHIFT        = 3,
    parameter logic [15:0] ACTIVATION_THRESH = 16'd30
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    vga_ready,
    input  logic [9:0]              x_count,
    input  logic [8:0]              y_count,
    input  logic                    enable,
    output logic                    frame_start,
    output logic [4:0]              cnt_rd_addr,
    input  logic [15:0]             cnt_rd_data,
    output logic                    busy,
    output logic                    overrun,
    output logic                    pattern_detected,
    output logic [4:0]              led_section,
    output logic [NUM_SECTIONS-1:0] section_leds
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_ACCUM   = 3'd2;
    localparam logic [2:0] ST_DECIDE  = 3'd3;
    localparam logic [2:0] ST_DISPLAY = 3'd4;

    localparam logic [9:0] X_LAST   = 10'(WIDTH - 1);
    localparam logic [8:0] Y_LAST   = 9'(HEIGHT - 1);
    localparam logic [4:0] LAST_IDX = 5'(NUM_SECTIONS - 1);
    localparam logic [NUM_SECTIONS-1:0] ONE_HOT = {{(NUM_SECTIONS-1){1'b0}}, 1'b1};

    // Leaky integrator: 15/16 decay of the old value plus the scaled raw count, saturated.
    function automatic logic [15:0] smooth_step(input logic [15:0] old_v, input logic [15:0] raw_v);
        logic [19:0] decay_v;
        logic [16:0] sum_v;
        decay_v = ({4'd0, old_v} * 20'd15) >> 4;
        sum_v   = {1'b0, decay_v[15:0]} + {1'b0, raw_v >> SMOOTH_FACTOR};
        return sum_v[16] ? 16'hFFFF : sum_v[15:0];
    endfunction

    logic [2:0]  state_r;
    logic [4:0]  idx_r;
    logic [15:0] max_val_r;
    logic [4:0]  max_idx_r;
    logic [4:0]  cur_sec_r;
    logic        pat_r;
    logic [15:0] smoothed_r [NUM_SECTIONS];

    logic        fs_evt_s;
    logic        fe_evt_s;
    logic [15:0] new_val_s;
    logic [15:0] cur_val_s;
    logic [16:0] hyst_limit_s;
    logic        pat_s;
    logic        switch_s;

    // Frame events, accumulator update and the hysteresis switch decision.
    always_comb begin
        fs_evt_s     = vga_ready && (x_count == 10'd0) && (y_count == 9'd0);
        fe_evt_s     = vga_ready && (x_count == X_LAST) && (y_count == Y_LAST);
        new_val_s    = smooth_step(smoothed_r[idx_r], cnt_rd_data);
        cur_val_s    = smoothed_r[cur_sec_r];
        hyst_limit_s = {1'b0, cur_val_s} + {1'b0, cur_val_s >> HYST_SHIFT};
        pat_s        = (max_val_r >= ACTIVATION_THRESH);
        switch_s     = pat_s && ((max_idx_r == cur_sec_r) ||
                                 ({1'b0, smoothed_r[max_idx_r]} > hyst_limit_s));
    end

    // Frame-start pulse and sticky overrun flag; both independent of the sweep FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_start <= fs_evt_s;
            if (fe_evt_s && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Smoothed history, written once per section during the accumulate step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                smoothed_r[i] <= 16'd0;
            end
        end else if (state_r == ST_ACCUM) begin
            smoothed_r[idx_r] <= new_val_s;
        end
    end

    // Sweep FSM: two cycles per section, then decide and display.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r          <= ST_IDLE;
            idx_r            <= 5'd0;
            max_val_r        <= 16'd0;
            max_idx_r        <= 5'd0;
            cur_sec_r        <= 5'd0;
            pat_r            <= 1'b0;
            cnt_rd_addr      <= 5'd0;
            busy             <= 1'b0;
            pattern_detected <= 1'b0;
            led_section      <= 5'd0;
            section_leds     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fe_evt_s && enable) begin
                        state_r     <= ST_FETCH;
                        idx_r       <= 5'd0;
                        max_val_r   <= 16'd0;
                        max_idx_r   <= 5'd0;
                        cnt_rd_addr <= 5'd0;
                        busy        <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    // Strict compare keeps the lowest index on ties.
                    if (new_val_s > max_val_r) begin
                        max_val_r <= new_val_s;
                        max_idx_r <= idx_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DECIDE;
                    end else begin
                        idx_r       <= idx_r + 5'd1;
                        cnt_rd_addr <= idx_r + 5'd1;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_DECIDE: begin
                    pat_r <= pat_s;
                    if (switch_s) begin
                        cur_sec_r <= max_idx_r;
                    end
                    state_r <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    pattern_detected <= pat_r;
                    led_section      <= cur_sec_r;
                    section_leds     <= pat_r ? (ONE_HOT << cur_sec_r) : '0;
                    busy             <= 1'b0;
                    state_r          <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_density_sweep_controller.sv
// Directed plus randomized bench for edge_density_sweep_controller against a frame-level model.
module tb_edge_density_sweep_controller;

    localparam int NS = 18;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vga_ready;
    logic [9:0]    x_count;
    logic [8:0]    y_count;
    logic          enable;
    logic          frame_start;
    logic [4:0]    cnt_rd_addr;
    logic [15:0]   cnt_rd_data;
    logic          busy;
    logic          overrun;
    logic          pattern_detected;
    logic [4:0]    led_section;
    logic [NS-1:0] section_leds;

    int n_checks = 0;
    int n_fail   = 0;

    int cnt_mem [NS];
    int sm      [NS];
    int cur_m;
    int exp_pat;
    int exp_led;
    int exp_leds;
    int exp_ovr;

    edge_density_sweep_controller dut (
        .clk(clk), .reset_n(reset_n), .vga_ready(vga_ready), .x_count(x_count),
        .y_count(y_count), .enable(enable), .frame_start(frame_start),
        .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(cnt_rd_data), .busy(busy),
        .overrun(overrun), .pattern_detected(pattern_detected),
        .led_section(led_section), .section_leds(section_leds)
    );

    always #5 clk = ~clk;

    // Section counter RAM with a registered read port.
    always @(posedge clk) begin
        cnt_rd_data <= (cnt_rd_addr < 5'(NS)) ? 16'(cnt_mem[cnt_rd_addr]) : 16'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) sm[i] = 0;
        cur_m = 0; exp_pat = 0; exp_led = 0; exp_leds = 0; exp_ovr = 0;
    endtask

    // One frame of the smoothing / peak / hysteresis rules in plain integer arithmetic.
    task automatic model_frame();
        int maxv, maxi, v;
        maxv = 0; maxi = 0;
        for (int i = 0; i < NS; i++) begin
            v = (sm[i] * 15) / 16 + cnt_mem[i] / 4;
            if (v > 65535) v = 65535;
            sm[i] = v;
            if (v > maxv) begin maxv = v; maxi = i; end
        end
        exp_pat = (maxv >= 30) ? 1 : 0;
        if (exp_pat == 1 && (maxi == cur_m || sm[maxi] > sm[cur_m] + sm[cur_m] / 8)) cur_m = maxi;
        exp_led  = cur_m;
        exp_leds = (exp_pat == 1) ? (1 << cur_m) : 0;
    endtask

    task automatic set_counts(input int a, input int b, input int va, input int vb, input int rest);
        for (int i = 0; i < NS; i++) cnt_mem[i] = rest;
        cnt_mem[a] = va;
        cnt_mem[b] = vb;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".pat"}, pattern_detected, exp_pat);
        chk({tag, ".led_section"}, led_section, exp_led);
        chk({tag, ".section_leds"}, section_leds, exp_leds);
        chk({tag, ".overrun"}, overrun, exp_ovr);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".frame_start"}, frame_start, 0);
        chk({tag, ".cnt_rd_addr"}, cnt_rd_addr, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".overrun"}, overrun, 0);
        chk({tag, ".pat"}, pattern_detected, 0);
        chk({tag, ".led_section"}, led_section, 0);
        chk({tag, ".section_leds"}, section_leds, 0);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Frame-end strobe at T, busy checked over T+1..T+38, outputs checked at T+39.
    task automatic sweep(input string tag, input int ovr_at, input int rst_at, input int en_drop_at);
        @(negedge clk);
        vga_ready = 1'b1; x_count = 10'd639; y_count = 9'd479;
        @(negedge clk);
        vga_ready = 1'b0; x_count = 10'd5; y_count = 9'd5;
        for (int i = 1; i <= 38; i++) begin
            if (i == rst_at) begin
                reset_n = 1'b0;
                #1;
                check_zero({tag, ".midreset"});
                @(negedge clk);
                reset_n = 1'b1;
                model_reset();
                return;
            end
            chk({tag, ".busy_window"}, busy, 1);
            if (i == en_drop_at) enable = 1'b0;
            if (i == ovr_at) begin vga_ready = 1'b1; x_count = 10'd639; y_count = 9'd479; end
            @(negedge clk);
            if (i == ovr_at) begin vga_ready = 1'b0; x_count = 10'd5; y_count = 9'd5; exp_ovr = 1; end
        end
        model_frame();
        check_outputs(tag);
        chk({tag, ".cnt_rd_addr_hold"}, cnt_rd_addr, 17);
        enable = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; vga_ready = 1'b1; x_count = 10'd100; y_count = 9'd50; enable = 1'b1;
        for (int i = 0; i < NS; i++) cnt_mem[i] = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("por");
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_fs_midframe", frame_start, 0);
        end
        vga_ready = 1'b1; x_count = 10'd0; y_count = 9'd0;
        @(negedge clk);
        vga_ready = 1'b0; x_count = 10'd5; y_count = 9'd5;
        chk("fs_pulse", frame_start, 1);
        @(negedge clk);
        chk("fs_one_cycle", frame_start, 0);

        // Single peak on section 5.
        set_counts(5, 5, 400, 400, 0);
        sweep("peak", 0, 0, 0);
        chk("peak.smoothed5", dut.smoothed_r[5], 100);

        // Challenger within hysteresis keeps section 5.
        set_counts(5, 9, 400, 860, 0);
        sweep("hyst_stay", 0, 0, 0);
        chk("hyst_stay.led5", led_section, 5);

        // Same start, challenger beyond hysteresis takes over.
        hard_reset();
        set_counts(5, 5, 400, 400, 0);
        sweep("peak2", 0, 0, 0);
        set_counts(5, 9, 400, 880, 0);
        sweep("hyst_switch", 0, 0, 0);
        chk("hyst_switch.leds", section_leds, 18'h00200);

        // Below threshold everywhere.
        hard_reset();
        set_counts(0, 0, 80, 80, 80);
        sweep("below", 0, 0, 0);

        // Tie resolves to the lowest index.
        hard_reset();
        set_counts(3, 7, 400, 400, 0);
        sweep("tie", 0, 0, 0);
        chk("tie.led3", led_section, 3);

        // Frame end during a sweep sets sticky overrun; enable drop mid-sweep still completes.
        set_counts(3, 11, 200, 900, 40);
        sweep("overrun", 10, 0, 6);
        set_counts(3, 11, 100, 100, 20);
        sweep("overrun_sticky", 0, 0, 0);

        // Disabled controller ignores frame end.
        enable = 1'b0;
        @(negedge clk);
        vga_ready = 1'b1; x_count = 10'd639; y_count = 9'd479;
        @(negedge clk);
        vga_ready = 1'b0; x_count = 10'd5; y_count = 9'd5;
        repeat (5) begin
            chk("disabled.busy", busy, 0);
            @(negedge clk);
        end
        check_outputs("disabled");
        enable = 1'b1;

        // Reset at T+20 aborts; history is lost.
        set_counts(5, 5, 400, 400, 0);
        sweep("abort", 0, 20, 0);
        sweep("after_abort", 0, 0, 0);
        chk("after_abort.smoothed5", dut.smoothed_r[5], 100);

        // Randomized frames, including saturating counts.
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 3) == 0) cnt_mem[i] = int'($urandom_range(0, 65535));
                else cnt_mem[i] = int'($urandom_range(0, 1200));
            end
            sweep("random", 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
